// File: rtl/dmem_responder.sv
// dmem_responder
//   Terminates LSU load/store traffic on a word-organised array. One request
//   is in flight at a time. A store writes its enabled byte lanes at the
//   accept edge. A load captures the addressed word at the accept edge. The
//   response is presented LAT cycles after accept and held until taken.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   req_valid    request present
//   req_ready    responder idle and able to accept
//   req_wen      1 = store, 0 = load
//   req_addr     byte address; word index = req_addr[AW+1:2]
//   req_wdata    lane-aligned store data
//   req_wmask    byte-lane write strobe
//   resp_valid   response present
//   resp_ready   initiator takes the response
//   resp_rdata   loaded word; 0 for stores and out-of-range accesses
//   resp_err     address had bits set above the array range
module dmem_responder #(
    parameter int XLEN = 32,
    parameter int AW   = 10,
    parameter int LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [XLEN/8-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err
);

    localparam int NB = XLEN / 8;
    // The counter runs LAT-2 down to 0 in WAIT; the extra edge is the
    // WAIT->RESP transition itself. LAT == 1 skips WAIT entirely.
    localparam int              CNT_INIT_I = (LAT >= 2) ? (LAT - 2) : 0;
    localparam logic [3:0]      CNT_INIT   = CNT_INIT_I[3:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    // No reset on the array: contents are undefined until written.
    logic [XLEN-1:0]   mem [2**AW];

    logic [AW-1:0]     widx;
    logic              oor;
    logic              accept;
    logic              wr_en;

    assign widx      = req_addr[AW+1:2];
    // Any address bit above the array window flags the access as an error.
    assign oor       = |(req_addr >> (AW + 2));
    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid & req_ready;
    // Reset wins over an accept on the same edge, including the array write.
    assign wr_en     = accept & req_wen & ~oor & ~rst;

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rdata_d = (!req_wen && !oor) ? mem[widx] : '0;
                    err_d   = oor;
                    cnt_d   = CNT_INIT;
                    if (LAT == 1) state_d = RESP;
                    else          state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (req_wmask[i]) mem[widx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

endmodule
